robs_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Robertson multiplier datapath/control pair (WIDTH-bit signed operands, 2·WIDTH-bit product, `done` flag) among NREQ requesters. It grants one requester at a time and latches that requester's operands. It starts the multiplier with a one-cycle start pulse, waits for a qualified `done`, and returns the product to the granted requester. A watchdog aborts the operation if the multiplier never reports `done`.

---
 rtl/robs_mult_arbiter.sv | 155 +++++++++++++++
 tb/tb_robs_mult_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/robs_mult_arbiter.sv
// Round-robin arbiter sharing one Robertson multiplier among NREQ requesters:
// latches operands, pulses start, waits for a qualified done (or times out), returns the product.
module robs_mult_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4 * WIDTH + 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*WIDTH-1:0]     a_in_i,
  input  logic [NREQ*WIDTH-1:0]     b_in_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           rsp_valid_o,
  output logic signed [2*WIDTH-1:0] rsp_product_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      mult_start_o,
  output logic signed [WIDTH-1:0]   mult_a_o,
  output logic signed [WIDTH-1:0]   mult_b_o,
  input  logic                      mult_done_i,
  input  logic signed [2*WIDTH-1:0] mult_product_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NREQ-1:0]           gnt_q, gnt_d;
  logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic signed [2*WIDTH-1:0] rsp_product_q, rsp_product_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      busy_q, busy_d;
  logic                      start_q, start_d;
  logic signed [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic signed [WIDTH-1:0]   mult_b_q, mult_b_d;

  logic                      sel_found;
  logic [IW-1:0]             sel_idx;
  int                        sel_j;

  // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_j     = 0;
    for (int off = 0; off < NREQ; off++) begin
      sel_j = (int'(rr_ptr_q) + off) % NREQ;
      if (!sel_found && req_i[sel_j]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(sel_j);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    rsp_valid_d   = '0;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    start_d       = 1'b0;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          idx_d          = sel_idx;
          mult_a_d       = a_in_i[int'(sel_idx)*WIDTH +: WIDTH];
          mult_b_d       = b_in_i[int'(sel_idx)*WIDTH +: WIDTH];
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          start_d        = 1'b1;
          state_d        = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done seen in the first WAIT cycle is left over from the previous operation.
        if (mult_done_i && (cnt_q != '0)) begin
          rsp_product_d = mult_product_i;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = gnt_q;
          state_d       = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = gnt_q;
          state_d       = S_RESP;
        end
      end
      default: begin
        rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      start_q       <= start_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_product_o = rsp_product_q;
  assign rsp_err_o     = rsp_err_q;
  assign busy_o        = busy_q;
  assign mult_start_o  = start_q;
  assign mult_a_o      = mult_a_q;
  assign mult_b_o      = mult_b_q;

endmodule

// File: tb/tb_robs_mult_arbiter.sv
// Bench for robs_mult_arbiter: behavioural multiplier with selectable done behaviour,
// expected responses queued at stimulus time and compared when rsp_valid fires.
module tb_robs_mult_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  a_in = '0;
  logic [N*W-1:0]  b_in = '0;
  logic [N-1:0]    gnt, rsp_valid;
  logic [2*W-1:0]  rsp_product;
  logic            rsp_err, busy, mult_start;
  logic [W-1:0]    mult_a, mult_b;
  logic            mult_done;
  logic [2*W-1:0]  mult_product;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  typedef struct {
    int         idx;
    logic [15:0] prod;
    logic       err;
  } exp_t;
  exp_t sb[$];

  robs_mult_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .a_in_i(a_in), .b_in_i(b_in),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_product_o(rsp_product), .rsp_err_o(rsp_err),
    .busy_o(busy), .mult_start_o(mult_start), .mult_a_o(mult_a), .mult_b_o(mult_b),
    .mult_done_i(mult_done), .mult_product_i(mult_product)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ea, eb;
    ea = {{8{a[7]}}, a};
    eb = {{8{b[7]}}, b};
    return ea * eb;
  endfunction

  // Behavioural multiplier: done 3 edges after the start edge, done stays high until the next op.
  logic        m_done_q = 1'b0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_prod_q = '0;
  logic [15:0] m_pend_prod = '0;
  always @(posedge clk) begin
    if (!reset_n) begin
      m_done_q <= 1'b0;
      m_pend   <= 1'b0;
      m_cnt    <= 0;
      m_prod_q <= '0;
    end else if (mult_start) begin
      m_pend      <= 1'b1;
      m_cnt       <= 3;
      m_pend_prod <= smul(mult_a, mult_b);
    end else if (m_pend) begin
      if (m_cnt == 1) begin
        m_done_q <= 1'b1;
        m_prod_q <= m_pend_prod;
        m_pend   <= 1'b0;
      end else begin
        m_cnt    <= m_cnt - 1;
        m_done_q <= 1'b0;
      end
    end
  end

  // Cycles since LAUNCH; equals the DUT wait counter while in WAIT.
  int wcnt = 100;
  always @(posedge clk) begin
    if (mult_start) wcnt <= 0;
    else if (wcnt < 1000) wcnt <= wcnt + 1;
  end
  logic stale_done;
  assign stale_done   = mult_start | (wcnt == 0) | (wcnt == 5);
  assign mult_done    = (mode == 0) ? m_done_q : (mode == 1) ? stale_done : 1'b0;
  assign mult_product = (mode == 1) ? 16'h1234 : m_prod_q;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    req = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rsp_valid != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req = '1;
    a_in = '1;
    b_in = '1;
    tick();
    tick();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", mult_start); end
    checks++; if ({mult_a, mult_b} !== '0) begin errors++; $display("FAIL reset_operands got %h want 0", {mult_a, mult_b}); end
    checks++; if ({rsp_product, rsp_err} !== '0) begin errors++; $display("FAIL reset_rsp got %h want 0", {rsp_product, rsp_err}); end
    req = '0;
    a_in = '0;
    b_in = '0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input logic [7:0] a, input logic [7:0] b, input logic [15:0] want);
    int c;
    exp_t e;
    mode = 0;
    a_in[W-1:0] = a;
    b_in[W-1:0] = b;
    req = 4'b0001;
    sb.push_back('{0, want, 1'b0});
    tick();
    checks++; if (!(mult_start === 1'b1 && gnt === 4'b0001)) begin errors++; $display("FAIL single_launch start %b gnt %b want 1 0001", mult_start, gnt); end
    req = '0;
    tick();
    checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL single_start_width got %b want 0", mult_start); end
    wait_rsp(c);
    checks++; if (c != 4) begin errors++; $display("FAIL single_latency got %0d want 4", c); end
    e = sb.pop_front();
    checks++; if (rsp_valid !== N'(1 << e.idx)) begin errors++; $display("FAIL single_rsp_valid got %b want idx %0d", rsp_valid, e.idx); end
    checks++; if (rsp_product !== e.prod) begin errors++; $display("FAIL single_product got %h want %h", rsp_product, e.prod); end
    checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL single_err got %b want %b", rsp_err, e.err); end
    tick();
  endtask

  task automatic test_fairness;
    int c;
    exp_t e;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    mode = 0;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = 8'(i + 3);
      b_in[i*W +: W] = 8'(-(i + 2));
    end
    for (int k = 0; k < 6; k++)
      sb.push_back('{order[k], smul(a_in[order[k]*W +: W], b_in[order[k]*W +: W]), 1'b0});
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(c);
      e = sb.pop_front();
      checks++; if (c != ((k == 0) ? 6 : 7)) begin errors++; $display("FAIL fair_spacing[%0d] got %0d want %0d", k, c, (k == 0) ? 6 : 7); end
      checks++; if (rsp_valid !== N'(1 << e.idx) || gnt !== rsp_valid) begin errors++; $display("FAIL fair_grant[%0d] rsp %b gnt %b want idx %0d", k, rsp_valid, gnt, e.idx); end
      checks++; if (rsp_product !== e.prod || rsp_err !== 1'b0) begin errors++; $display("FAIL fair_product[%0d] got %h/%b want %h/0", k, rsp_product, rsp_err, e.prod); end
    end
    req = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_idle busy got %b want 0", busy); end
  endtask

  task automatic test_stale_done;
    int c;
    exp_t e;
    apply_reset();
    mode = 1;
    a_in[W-1:0] = 8'h11;
    req = 4'b0001;
    sb.push_back('{0, 16'h1234, 1'b0});
    tick();
    req = '0;
    wait_rsp(c);
    e = sb.pop_front();
    checks++; if (c != 7) begin errors++; $display("FAIL stale_latency got %0d want 7", c); end
    checks++; if (rsp_valid !== N'(1 << e.idx) || rsp_product !== e.prod || rsp_err !== e.err) begin
      errors++; $display("FAIL stale_rsp got %b/%h/%b want idx %0d %h 0", rsp_valid, rsp_product, rsp_err, e.idx, e.prod); end
    mode = 0;
    tick();
  endtask

  task automatic test_timeout;
    int c;
    exp_t e;
    apply_reset();
    mode = 2;
    a_in[1*W +: W] = 8'h09;
    b_in[1*W +: W] = 8'hF9;
    sb.push_back('{0, 16'h0000, 1'b1});
    sb.push_back('{1, smul(8'h09, 8'hF9), 1'b0});
    req = 4'b0011;
    wait_rsp(c);
    e = sb.pop_front();
    checks++; if (c != TO + 2) begin errors++; $display("FAIL timeout_latency got %0d want %0d", c, TO + 2); end
    checks++; if (rsp_valid !== N'(1 << e.idx) || rsp_product !== e.prod || rsp_err !== e.err) begin
      errors++; $display("FAIL timeout_rsp got %b/%h/%b want idx %0d %h 1", rsp_valid, rsp_product, rsp_err, e.idx, e.prod); end
    mode = 0;
    req = 4'b0010;
    wait_rsp(c);
    e = sb.pop_front();
    checks++; if (c != 7) begin errors++; $display("FAIL timeout_next_latency got %0d want 7", c); end
    checks++; if (rsp_valid !== N'(1 << e.idx) || rsp_product !== e.prod || rsp_err !== e.err) begin
      errors++; $display("FAIL timeout_next_rsp got %b/%h/%b want idx %0d %h 0", rsp_valid, rsp_product, rsp_err, e.idx, e.prod); end
    req = '0;
    tick();
  endtask

  task automatic test_isolation;
    int c;
    exp_t e;
    apply_reset();
    mode = 0;
    a_in[1*W +: W] = 8'h07;
    b_in[1*W +: W] = 8'h06;
    sb.push_back('{1, 16'h002A, 1'b0});
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL iso_gnt got %b want 0010", gnt); end
    tick();
    a_in[1*W +: W] = 8'h55;
    req = '0;
    tick();
    checks++; if (mult_a !== 8'h07 || mult_b !== 8'h06) begin errors++; $display("FAIL iso_operands got %h/%h want 07/06", mult_a, mult_b); end
    wait_rsp(c);
    e = sb.pop_front();
    checks++; if (c != 3) begin errors++; $display("FAIL iso_latency got %0d want 3", c); end
    checks++; if (rsp_valid !== N'(1 << e.idx) || rsp_product !== e.prod || rsp_err !== e.err) begin
      errors++; $display("FAIL iso_rsp got %b/%h/%b want idx %0d %h 0", rsp_valid, rsp_product, rsp_err, e.idx, e.prod); end
    checks++; if (mult_a !== 8'h07) begin errors++; $display("FAIL iso_hold got %h want 07", mult_a); end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    int c;
    int bad;
    exp_t e;
    apply_reset();
    mode = 0;
    a_in[1*W +: W] = 8'h03;
    b_in[1*W +: W] = 8'h04;
    a_in[2*W +: W] = 8'h05;
    b_in[2*W +: W] = 8'h05;
    sb.push_back('{1, 16'd12, 1'b0});
    req = 4'b0010;
    wait_rsp(c);
    e = sb.pop_front();
    checks++; if (rsp_valid !== N'(1 << e.idx) || rsp_product !== e.prod) begin errors++; $display("FAIL rmw_pre got %b/%h want idx %0d %h", rsp_valid, rsp_product, e.idx, e.prod); end
    req = '0;
    tick();
    mode = 2;
    req = 4'b0010;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1 || gnt !== 4'b0010) begin errors++; $display("FAIL rmw_in_wait busy %b gnt %b want 1 0010", busy, gnt); end
    reset_n = 1'b0;
    req = '0;
    tick();
    checks++; if ({gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b} !== '0) begin
      errors++; $display("FAIL rmw_outputs got %h want 0", {gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b}); end
    reset_n = 1'b1;
    mode = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmw_quiet got %0d active cycles want 0", bad); end
    sb.push_back('{1, 16'd12, 1'b0});
    sb.push_back('{2, 16'd25, 1'b0});
    req = 4'b0110;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmw_first_grant got %b want 0010", gnt); end
    for (int k = 0; k < 2; k++) begin
      wait_rsp(c);
      e = sb.pop_front();
      checks++; if (c != ((k == 0) ? 5 : 7)) begin errors++; $display("FAIL rmw_latency[%0d] got %0d want %0d", k, c, (k == 0) ? 5 : 7); end
      checks++; if (rsp_valid !== N'(1 << e.idx) || rsp_product !== e.prod || rsp_err !== 1'b0) begin
        errors++; $display("FAIL rmw_rsp[%0d] got %b/%h/%b want idx %0d %h 0", k, rsp_valid, rsp_product, rsp_err, e.idx, e.prod); end
    end
    req = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(8'h05, 8'hFD, 16'hFFF1);
    test_single(8'h80, 8'h80, 16'h4000);
    test_fairness();
    test_stale_done();
    test_timeout();
    test_isolation();
    test_reset_mid_wait();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
